// File: rtl/sparse_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sparse_pkg
// Purpose : Shared constants, lane-width helper and descriptor type for the
//           sparse stream expander and its descriptor buffer.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package sparse_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_LANES_DEF  = 8;

  // Width of a lane index; never narrower than one bit.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Compressed row descriptor at the default geometry.
  typedef struct packed {
    logic [NUM_LANES_DEF-1:0]                bitmap;
    logic [NUM_LANES_DEF*DATA_WIDTH_DEF-1:0] values;
    logic                                    tile_last;
  } desc_t;

endpackage
`default_nettype wire

// File: rtl/sparse_desc_buf.sv
`default_nettype none
// ============================================================================
// Module  : sparse_desc_buf
// Purpose : Two-entry (active + shadow) descriptor buffer. The active entry
//           is the row currently being expanded; the shadow holds the next
//           row so the expander never idles between back-to-back rows.
// Ports   : clk, rst        clock, asynchronous active-high reset
//           push_i          a descriptor is accepted this cycle
//           push_desc_i     the accepted descriptor
//           pop_i           the active row finishes this cycle
//           act_valid_o     active entry holds a row
//           act_desc_o      active descriptor
//           shd_valid_o     shadow entry holds a row
// Revision: 1.0  initial release
// ============================================================================
module sparse_desc_buf
  import sparse_pkg::*;
#(
  parameter int DESC_W = NUM_LANES_DEF * (DATA_WIDTH_DEF + 1) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DESC_W-1:0] push_desc_i,
  input  logic              pop_i,
  output logic              act_valid_o,
  output logic [DESC_W-1:0] act_desc_o,
  output logic              shd_valid_o
);

  logic              act_valid_q, act_valid_d;
  logic              shd_valid_q, shd_valid_d;
  logic [DESC_W-1:0] act_desc_q,  act_desc_d;
  logic [DESC_W-1:0] shd_desc_q,  shd_desc_d;

  always_comb begin
    act_valid_d = act_valid_q;
    shd_valid_d = shd_valid_q;
    act_desc_d  = act_desc_q;
    shd_desc_d  = shd_desc_q;
    if (pop_i) begin
      if (shd_valid_q) begin
        // Promote the waiting row; an arrival refills the shadow.
        act_desc_d  = shd_desc_q;
        shd_valid_d = push_i;
        if (push_i) begin
          shd_desc_d = push_desc_i;
        end
      end else if (push_i) begin
        // Arrival on the last element goes straight to active.
        act_desc_d = push_desc_i;
      end else begin
        act_valid_d = 1'b0;
      end
    end else if (push_i) begin
      if (!act_valid_q) begin
        act_desc_d  = push_desc_i;
        act_valid_d = 1'b1;
      end else begin
        shd_desc_d  = push_desc_i;
        shd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_valid_q <= 1'b0;
      shd_valid_q <= 1'b0;
      act_desc_q  <= '0;
      shd_desc_q  <= '0;
    end else begin
      act_valid_q <= act_valid_d;
      shd_valid_q <= shd_valid_d;
      act_desc_q  <= act_desc_d;
      shd_desc_q  <= shd_desc_d;
    end
  end

  assign act_valid_o = act_valid_q;
  assign act_desc_o  = act_desc_q;
  assign shd_valid_o = shd_valid_q;

endmodule
`default_nettype wire

// File: rtl/sparse_stream_expander.sv
`default_nettype none
// ============================================================================
// Module  : sparse_stream_expander
// Purpose : Expands compressed row descriptors (nonzero bitmap + packed
//           nonzero values) into a dense one-element-per-cycle stream with a
//           per-element sparse index, plus saturating nnz/zero statistics.
// Ports   : clk, rst           clock, asynchronous active-high reset
//           in_valid/in_ready  descriptor handshake
//           in_bitmap          lane nonzero bitmap
//           in_values          packed nonzero values, slice 0 at LSBs
//           in_tile_last       descriptor closes a tile
//           out_valid/out_ready element handshake
//           out_data           element value (0 for zero lanes)
//           out_sparse_index   bitmap bit of the current lane
//           out_lane           current lane index
//           out_row_last       last lane of the row
//           out_tile_last      last lane of a tile-closing row
//           stat_nnz/stat_zero saturating element counters
//           stat_clr           synchronous counter clear
// Revision: 1.0  initial release
// ============================================================================
module sparse_stream_expander
  import sparse_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES-1:0]            in_bitmap,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_values,
  input  logic                            in_tile_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_sparse_index,
  output logic [lane_w(NUM_LANES)-1:0]    out_lane,
  output logic                            out_row_last,
  output logic                            out_tile_last,
  output logic [CNT_WIDTH-1:0]            stat_nnz,
  output logic [CNT_WIDTH-1:0]            stat_zero,
  input  logic                            stat_clr
);

  localparam int LW     = lane_w(NUM_LANES);
  localparam int VW     = NUM_LANES * DATA_WIDTH;
  localparam int DESC_W = NUM_LANES + VW + 1;

  localparam logic [LW-1:0]        LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [LW-1:0]        LANE_ONE  = LW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [LW-1:0]        ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] nnz_q, nnz_d;
  logic [CNT_WIDTH-1:0] zero_q, zero_d;
  // Keeps in_ready low while reset is asserted and for the first edge after.
  logic                 run_q;

  logic              act_valid, shd_valid;
  logic [DESC_W-1:0] in_desc, act_desc;
  logic [NUM_LANES-1:0] act_bitmap;
  logic [VW-1:0]     act_values;
  logic              act_tile_last;
  logic [DATA_WIDTH-1:0] act_slices [NUM_LANES];

  logic accept, hs, at_last, row_done, cur_bit;
  logic [DATA_WIDTH-1:0] cur_val;

  assign in_desc = {in_bitmap, in_values, in_tile_last};
  assign {act_bitmap, act_values, act_tile_last} = act_desc;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_slice
      assign act_slices[g] = act_values[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign in_ready  = run_q & ~shd_valid;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_EXPAND) & act_valid;
  assign hs        = out_valid & out_ready;
  assign at_last   = (lane_q == LAST_LANE);
  assign row_done  = hs & at_last;
  assign cur_bit   = act_bitmap[lane_q];
  assign cur_val   = act_slices[ptr_q];

  sparse_desc_buf #(
    .DESC_W (DESC_W)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_desc_i (in_desc),
    .pop_i       (row_done),
    .act_valid_o (act_valid),
    .act_desc_o  (act_desc),
    .shd_valid_o (shd_valid)
  );

  // Next state and lane/value-pointer walk.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (hs) begin
          if (at_last) begin
            lane_d = '0;
            ptr_d  = '0;
            // Continue only if another row is ready now (shadow or direct).
            if (!shd_valid && !accept) begin
              state_d = ST_IDLE;
            end
          end else begin
            lane_d = lane_q + LANE_ONE;
            if (cur_bit) begin
              ptr_d = ptr_q + LANE_ONE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        lane_d  = '0;
        ptr_d   = '0;
      end
    endcase
  end

  // Saturating statistics; a clear in the same cycle beats an increment.
  always_comb begin
    nnz_d  = nnz_q;
    zero_d = zero_q;
    if (stat_clr) begin
      nnz_d  = '0;
      zero_d = '0;
    end else if (hs) begin
      if (cur_bit) begin
        if (nnz_q != CNT_MAX) begin
          nnz_d = nnz_q + CNT_ONE;
        end
      end else begin
        if (zero_q != CNT_MAX) begin
          zero_d = zero_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      ptr_q   <= '0;
      nnz_q   <= '0;
      zero_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      ptr_q   <= ptr_d;
      nnz_q   <= nnz_d;
      zero_q  <= zero_d;
      run_q   <= 1'b1;
    end
  end

  // Element outputs are forced to 0 whenever no element is presented.
  assign out_sparse_index = out_valid & cur_bit;
  assign out_data         = out_sparse_index ? cur_val : '0;
  assign out_lane         = out_valid ? lane_q : '0;
  assign out_row_last     = out_valid & at_last;
  assign out_tile_last    = out_row_last & act_tile_last;
  assign stat_nnz         = nnz_q;
  assign stat_zero        = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_sparse_stream_expander.sv
`default_nettype none
// ============================================================================
// Module  : tb_sparse_stream_expander
// Purpose : Directed self-checking bench for sparse_stream_expander.
// Revision: 1.0  initial release
// ============================================================================
module tb_sparse_stream_expander;
  import sparse_pkg::*;

  localparam int DW = 8;
  localparam int NL = 8;
  localparam int CW = 16;
  localparam int LW = lane_w(NL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [NL-1:0] in_bitmap = '0;
  logic [NL*DW-1:0] in_values = '0;
  logic in_tile_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic out_sparse_index;
  logic [LW-1:0] out_lane;
  logic out_row_last;
  logic out_tile_last;
  logic [CW-1:0] stat_nnz;
  logic [CW-1:0] stat_zero;
  logic stat_clr = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sparse_stream_expander #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_bitmap        (in_bitmap),
    .in_values        (in_values),
    .in_tile_last     (in_tile_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_sparse_index (out_sparse_index),
    .out_lane         (out_lane),
    .out_row_last     (out_row_last),
    .out_tile_last    (out_tile_last),
    .stat_nnz         (stat_nnz),
    .stat_zero        (stat_zero),
    .stat_clr         (stat_clr)
  );

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_bitmap = '0;
    in_values = '0;
    in_tile_last = 1'b0;
    out_ready = 1'b0;
    stat_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents one descriptor from a falling edge and returns on the falling
  // edge after it was accepted.
  task automatic send_one(input logic [NL-1:0] bm, input logic [NL*DW-1:0] vals,
                          input logic tl);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_bitmap = bm;
    in_values = vals;
    in_tile_last = tl;
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: in_ready never seen (got 0 required 1)");
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h required 00", out_data); end
    checks++; if (out_lane !== 3'd0) begin errors++; $display("FAIL rst_out_lane: got %0d required 0", out_lane); end
    checks++; if ({out_sparse_index, out_row_last, out_tile_last} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b required 000", {out_sparse_index, out_row_last, out_tile_last}); end
    checks++; if (stat_nnz !== 16'h0 || stat_zero !== 16'h0) begin errors++; $display("FAIL rst_stats: got %h/%h required 0000/0000", stat_nnz, stat_zero); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_single();
    logic       exp_idx [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp_dat [8] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h33, 8'h00, 8'h44};
    apply_reset();
    out_ready = 1'b1;
    send_one(8'b1010_0101, 64'h0000_0000_4433_2211, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid lane %0d: got %b required 1", i, out_valid); end
      checks++; if (out_lane !== LW'(i)) begin errors++; $display("FAIL single_lane: got %0d required %0d", out_lane, i); end
      checks++; if (out_sparse_index !== exp_idx[i]) begin errors++; $display("FAIL single_idx lane %0d: got %b required %b", i, out_sparse_index, exp_idx[i]); end
      checks++; if (out_data !== exp_dat[i]) begin errors++; $display("FAIL single_data lane %0d: got %h required %h", i, out_data, exp_dat[i]); end
      checks++; if (out_row_last !== (i == 7)) begin errors++; $display("FAIL single_row_last lane %0d: got %b required %b", i, out_row_last, (i == 7)); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b required 0", out_valid); end
    checks++; if (stat_nnz !== 16'd4) begin errors++; $display("FAIL single_nnz: got %0d required 4", stat_nnz); end
    checks++; if (stat_zero !== 16'd4) begin errors++; $display("FAIL single_zero: got %0d required 4", stat_zero); end
  endtask

  task automatic test_back_to_back();
    logic [NL-1:0]    bm [3] = '{8'hFF, 8'h00, 8'h81};
    logic [NL*DW-1:0] vl [3] = '{64'h0807_0605_0403_0201, 64'h0, 64'h0000_0000_0000_B2A1};
    logic       e_idx [24];
    logic [7:0] e_dat [24];
    int tl_count;
    for (int e = 0; e < 24; e++) begin
      e_idx[e] = 1'b0;
      e_dat[e] = 8'h00;
      if (e < 8) begin
        e_idx[e] = 1'b1;
        e_dat[e] = 8'(e + 1);
      end
    end
    e_idx[16] = 1'b1; e_dat[16] = 8'hA1;
    e_idx[23] = 1'b1; e_dat[23] = 8'hB2;
    tl_count = 0;
    apply_reset();
    out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          bit ok;
          ok = 1'b0;
          in_valid = 1'b1;
          in_bitmap = bm[k];
          in_values = vl[k];
          in_tile_last = (k == 2);
          for (int t = 0; t < 40 && !ok; t++) begin
            ok = in_ready;
            @(negedge clk);
          end
          checks++;
          if (!ok) begin errors++; $display("FAIL b2b_accept desc %0d: got 0 required 1", k); end
        end
        in_valid = 1'b0;
        in_tile_last = 1'b0;
      end
      begin
        for (int t = 0; t < 20 && out_valid !== 1'b1; t++) @(negedge clk);
        for (int e = 0; e < 24; e++) begin
          checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap at element %0d: got %b required 1", e, out_valid); end
          checks++; if (out_lane !== LW'(e % 8)) begin errors++; $display("FAIL b2b_lane element %0d: got %0d required %0d", e, out_lane, e % 8); end
          checks++; if (out_sparse_index !== e_idx[e] || out_data !== e_dat[e]) begin errors++; $display("FAIL b2b_elem %0d: got (%b,%h) required (%b,%h)", e, out_sparse_index, out_data, e_idx[e], e_dat[e]); end
          checks++; if (out_tile_last !== (e == 23)) begin errors++; $display("FAIL b2b_tile_last element %0d: got %b required %b", e, out_tile_last, (e == 23)); end
          if (out_tile_last === 1'b1) tl_count++;
          @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b required 0", out_valid); end
        checks++; if (tl_count != 1) begin errors++; $display("FAIL b2b_tile_pulses: got %0d required 1", tl_count); end
      end
    join
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 1'b1;
    send_one(8'hFF, 64'hC7C6_C5C4_C3C2_C1C0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_lane !== LW'(i) || out_data !== 8'(8'hC0 + i)) begin errors++; $display("FAIL stall_pre lane %0d: got (%0d,%h) required (%0d,%h)", i, out_lane, out_data, i, 8'hC0 + i); end
      @(negedge clk);
    end
    checks++; if (out_lane !== 3'd3 || out_data !== 8'hC3) begin errors++; $display("FAIL stall_enter: got (%0d,%h) required (3,c3)", out_lane, out_data); end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_lane !== 3'd3 || out_data !== 8'hC3 || out_sparse_index !== 1'b1) begin errors++; $display("FAIL stall_hold cycle %0d: got (v%b,%0d,%h,i%b) required (v1,3,c3,i1)", s, out_valid, out_lane, out_data, out_sparse_index); end
    end
    out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      checks++; if (out_lane !== LW'(i) || out_data !== 8'(8'hC0 + i)) begin errors++; $display("FAIL stall_resume lane %0d: got (%0d,%h) required (%0d,%h)", i, out_lane, out_data, i, 8'hC0 + i); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_end_valid: got %b required 0", out_valid); end
    checks++; if (stat_nnz !== 16'd8 || stat_zero !== 16'd0) begin errors++; $display("FAIL stall_stats: got %0d/%0d required 8/0", stat_nnz, stat_zero); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    send_one(8'hFF, 64'h1716_1514_1312_1110, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (out_lane !== 3'd3 || stat_nnz !== 16'd3) begin errors++; $display("FAIL midrst_pre: got (%0d,%0d) required (3,3)", out_lane, stat_nnz); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
    checks++; if (stat_nnz !== 16'd0 || stat_zero !== 16'd0) begin errors++; $display("FAIL midrst_stats: got %0d/%0d required 0/0", stat_nnz, stat_zero); end
    checks++; if (out_lane !== 3'd0 || out_data !== 8'h00) begin errors++; $display("FAIL midrst_outs: got (%0d,%h) required (0,00)", out_lane, out_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_one(8'h01, 64'h0000_0000_0000_005A, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_lane !== 3'd0 || out_sparse_index !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL midrst_new0: got (v%b,%0d,i%b,%h) required (v1,0,i1,5a)", out_valid, out_lane, out_sparse_index, out_data); end
    @(negedge clk);
    checks++; if (out_lane !== 3'd1 || out_sparse_index !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL midrst_new1: got (%0d,i%b,%h) required (1,i0,00)", out_lane, out_sparse_index, out_data); end
    repeat (7) @(negedge clk);
  endtask

  task automatic test_stat_clr();
    apply_reset();
    out_ready = 1'b1;
    send_one(8'h01, 64'h0000_0000_0000_0077, 1'b0);
    checks++; if (out_sparse_index !== 1'b1) begin errors++; $display("FAIL clr_pre_idx: got %b required 1", out_sparse_index); end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checks++; if (stat_nnz !== 16'd0 || stat_zero !== 16'd0) begin errors++; $display("FAIL clr_wins: got %0d/%0d required 0/0", stat_nnz, stat_zero); end
    checks++; if (out_lane !== 3'd1) begin errors++; $display("FAIL clr_lane: got %0d required 1", out_lane); end
    repeat (7) @(negedge clk);
    checks++; if (stat_nnz !== 16'd0 || stat_zero !== 16'd7) begin errors++; $display("FAIL clr_after: got %0d/%0d required 0/7", stat_nnz, stat_zero); end
  endtask

  task automatic test_saturation();
    int hs;
    bit w;
    hs = 0;
    apply_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_bitmap = 8'hFF;
    in_values = 64'h8877_6655_4433_2211;
    in_tile_last = 1'b0;
    for (int c = 0; c < 70000 && hs < 65539; c++) begin
      w = out_valid & out_ready;
      @(negedge clk);
      if (w) begin
        hs++;
        if (hs == 65534) begin
          checks++; if (stat_nnz !== 16'hFFFE) begin errors++; $display("FAIL sat_below: got %h required fffe", stat_nnz); end
        end
        if (hs == 65535) begin
          checks++; if (stat_nnz !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h required ffff", stat_nnz); end
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (hs != 65539) begin errors++; $display("FAIL sat_handshakes: got %0d required 65539", hs); end
    for (int t = 0; t < 40 && out_valid === 1'b1; t++) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain: got %b required 0", out_valid); end
    checks++; if (stat_nnz !== 16'hFFFF || stat_zero !== 16'h0) begin errors++; $display("FAIL sat_hold: got %h/%h required ffff/0000", stat_nnz, stat_zero); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_stat_clr();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
